// File: rtl/deserializer_frame_buf_if.sv
// Bundles the sample-input and frame-output handshakes of the deserializer.
// DESERIALIZER_FLUSH_EN adds the recv_last early-termination flag.
interface deserializer_frame_buf_if #(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8,
  parameter int CNT_W     = $clog2(N_SAMPLES + 1)
);
  logic [CNT_W-1:0]               cfg_len;
  logic [BIT_WIDTH-1:0]           recv_msg;
  logic                           recv_val;
`ifdef DESERIALIZER_FLUSH_EN
  logic                           recv_last;
`endif
  logic                           recv_rdy;
  logic [BIT_WIDTH*N_SAMPLES-1:0] send_msg;
  logic                           send_val;
  logic                           send_rdy;
  logic [CNT_W-1:0]               send_len;

`ifdef DESERIALIZER_FLUSH_EN
  modport master (
    output cfg_len, recv_msg, recv_val, recv_last, send_rdy,
    input  recv_rdy, send_msg, send_val, send_len
  );
  modport slave (
    input  cfg_len, recv_msg, recv_val, recv_last, send_rdy,
    output recv_rdy, send_msg, send_val, send_len
  );
`else
  modport master (
    output cfg_len, recv_msg, recv_val, send_rdy,
    input  recv_rdy, send_msg, send_val, send_len
  );
  modport slave (
    input  cfg_len, recv_msg, recv_val, send_rdy,
    output recv_rdy, send_msg, send_val, send_len
  );
`endif
endinterface

// File: rtl/deserializer_frame_buf.sv
// Serial-to-parallel frame deserializer with a fill buffer and an output
// register, so the next frame can load while the previous one waits on
// send_rdy. Frame length is latched from cfg_len on each frame's first sample.
// Optional feature macro: DESERIALIZER_FLUSH_EN (recv_last ends a frame early).
module deserializer_frame_buf #(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  deserializer_frame_buf_if.slave bus
);
  localparam int CNT_W   = $clog2(N_SAMPLES + 1);
  localparam int FRAME_W = BIT_WIDTH * N_SAMPLES;
  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(N_SAMPLES);

  typedef enum logic {FILL, HOLD} state_e;

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] fill_q, fill_d, fill_next;
  logic [FRAME_W-1:0] out_msg_q, out_msg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   out_len_q, out_len_d;
  logic               out_val_q, out_val_d;
  logic [CNT_W-1:0]   cfg_clamped, frame_len;
  logic               recv_rdy, recv_fire, send_fire;
  logic               flush_hit, frame_done, can_load;

`ifdef DESERIALIZER_FLUSH_EN
  assign flush_hit = bus.recv_last;
`else
  assign flush_hit = 1'b0;
`endif

  // Handshake decode, length clamping and end-of-frame detection
  always_comb begin
    recv_fire   = bus.recv_val && recv_rdy;
    send_fire   = out_val_q && bus.send_rdy;
    cfg_clamped = ((bus.cfg_len == '0) || (bus.cfg_len > MAX_LEN)) ? MAX_LEN : bus.cfg_len;
    frame_len   = (cnt_q == '0) ? cfg_clamped : len_q;
    cnt_inc     = cnt_q + 1'b1;
    frame_done  = recv_fire && ((cnt_inc == frame_len) || flush_hit);
    can_load    = !out_val_q || send_fire;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FILL;
    else        state_q <= state_d;
  end

  // Next state: park in HOLD when a frame completes but the output reg is busy
  always_comb begin
    state_d = state_q;
    if (state_q == FILL) begin
      if (frame_done && !can_load) state_d = HOLD;
    end else begin
      if (send_fire) state_d = FILL;
    end
  end

  // Output decode: input ready is a pure function of the registered state
  always_comb begin
    recv_rdy = (state_q == FILL);
  end

  // Fill buffer with the incoming sample dropped into its lane
  always_comb begin
    fill_next = fill_q;
    for (int i = 0; i < N_SAMPLES; i++) begin
      if (CNT_W'(i) == cnt_q) fill_next[BIT_WIDTH*i +: BIT_WIDTH] = bus.recv_msg;
    end
  end

  // Datapath next values: fill, latch length, hand frames to the output reg
  always_comb begin
    fill_d    = fill_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    out_msg_d = out_msg_q;
    out_len_d = out_len_q;
    out_val_d = out_val_q;
    if (send_fire) out_val_d = 1'b0;
    if (state_q == HOLD) begin
      if (send_fire) begin
        out_msg_d = fill_q;
        out_len_d = cnt_q;
        out_val_d = 1'b1;
        fill_d    = '0;
        cnt_d     = '0;
      end
    end else if (recv_fire) begin
      if (cnt_q == '0) len_d = cfg_clamped;
      if (frame_done && can_load) begin
        out_msg_d = fill_next;
        out_len_d = cnt_inc;
        out_val_d = 1'b1;
        fill_d    = '0;
        cnt_d     = '0;
      end else begin
        fill_d = fill_next;
        cnt_d  = cnt_inc;
      end
    end
  end

  // Datapath registers; reset discards any partial frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_q    <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      out_msg_q <= '0;
      out_len_q <= '0;
      out_val_q <= 1'b0;
    end else begin
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      out_msg_q <= out_msg_d;
      out_len_q <= out_len_d;
      out_val_q <= out_val_d;
    end
  end

  assign bus.recv_rdy = recv_rdy;
  assign bus.send_msg = out_msg_q;
  assign bus.send_len = out_len_q;
  assign bus.send_val = out_val_q;
endmodule

// File: tb/tb_deserializer_frame_buf.sv
// Self-checking bench for deserializer_frame_buf: directed scenarios followed
// by a randomized stall run, all scored against a frame-level reference model.
module tb_deserializer_frame_buf;
  localparam int BW    = 32;
  localparam int NS    = 8;
  localparam int CW    = $clog2(NS + 1);
  localparam int W     = BW * NS;

  logic clk;
  logic reset;

  deserializer_frame_buf_if #(.BIT_WIDTH(BW), .N_SAMPLES(NS)) bus ();

  deserializer_frame_buf #(.BIT_WIDTH(BW), .N_SAMPLES(NS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total;
  int bad;

  // Reference model: completed frames awaiting delivery plus the frame being built
  logic [W-1:0] exp_msg[$];
  int           exp_len[$];
  logic [W-1:0] cur_msg;
  int           cur_cnt;
  int           cur_len;
  int           accepted;
  int           sent_lanes;
  logic         drv_last;

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic val, input logic [BW-1:0] msg, input logic last,
                               input logic srdy, input logic [CW-1:0] len);
    bus.recv_val = val;
    bus.recv_msg = msg;
    drv_last     = last;
`ifdef DESERIALIZER_FLUSH_EN
    bus.recv_last = last;
`endif
    bus.send_rdy = srdy;
    bus.cfg_len  = len;
  endtask

  task automatic modelClear();
    exp_msg.delete();
    exp_len.delete();
    cur_msg = '0;
    cur_cnt = 0;
    cur_len = 0;
  endtask

  task automatic modelAccept(input logic [BW-1:0] d, input logic last, input int cfg);
    if (cur_cnt == 0) cur_len = (cfg == 0 || cfg > NS) ? NS : cfg;
    cur_msg[BW*cur_cnt +: BW] = d;
    cur_cnt++;
    if (cur_cnt == cur_len || last) begin
      exp_msg.push_back(cur_msg);
      exp_len.push_back(cur_cnt);
      cur_msg = '0;
      cur_cnt = 0;
    end
  endtask

  // One clock: check outputs against the model, account for fires, advance
  task automatic stepCycle();
    logic rf;
    logic sf;
    logic lst;
    checkOutput("send_val", W'(bus.send_val), W'(exp_msg.size() > 0));
    checkOutput("recv_rdy", W'(bus.recv_rdy), W'(exp_msg.size() < 2));
    if (bus.send_val && exp_msg.size() > 0) begin
      checkOutput("send_msg", bus.send_msg, exp_msg[0]);
      checkOutput("send_len", W'(bus.send_len), W'(exp_len[0]));
    end
    rf  = bus.recv_val && bus.recv_rdy;
    sf  = bus.send_val && bus.send_rdy;
    lst = drv_last;
    if (sf && exp_msg.size() > 0) begin
      sent_lanes += exp_len[0];
      void'(exp_msg.pop_front());
      void'(exp_len.pop_front());
    end
    if (rf) begin
      accepted++;
      modelAccept(bus.recv_msg, lst, int'(bus.cfg_len));
    end
    @(posedge clk);
    #1;
  endtask

  // Offer samples base, base+1, ... until n have been accepted (bounded)
  task automatic feed(input int n, input logic [BW-1:0] base, input logic srdy, input logic [CW-1:0] len);
    int got;
    int guard;
    got   = 0;
    guard = 0;
    while (got < n && guard < 20 * n + 20) begin
      applyStimulus(1'b1, base + BW'(got), 1'b0, srdy, len);
      if (bus.recv_rdy) got++;
      stepCycle();
      guard++;
    end
    checkOutput("feed_budget", W'(got), W'(n));
    applyStimulus(1'b0, '0, 1'b0, srdy, len);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    applyStimulus(1'b0, '0, 1'b0, 1'b1, bus.cfg_len);
    while (exp_msg.size() > 0 && guard < 50) begin
      stepCycle();
      guard++;
    end
    checkOutput("drain_empty", W'(exp_msg.size()), W'(0));
    applyStimulus(1'b0, '0, 1'b0, 1'b0, bus.cfg_len);
  endtask

  initial begin
    logic [W-1:0] exp_frame;
    int guard;
    int acc0;
    int sent0;
    total      = 0;
    bad        = 0;
    accepted   = 0;
    sent_lanes = 0;
    drv_last   = 1'b0;
    modelClear();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, CW'(8));

    // Reset state
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_send_val", W'(bus.send_val), W'(0));
    checkOutput("rst_send_msg", bus.send_msg, '0);
    checkOutput("rst_send_len", W'(bus.send_len), W'(0));
    checkOutput("rst_recv_rdy", W'(bus.recv_rdy), W'(1));

    // Scenario 1: reset mid-frame discards the partial frame
    $display("[TB] reset mid-frame");
    feed(3, 32'hA0, 1'b0, CW'(8));
    reset = 1'b0;
    #1;
    checkOutput("midrst_send_val", W'(bus.send_val), W'(0));
    checkOutput("midrst_send_msg", bus.send_msg, '0);
    modelClear();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    feed(8, 32'd1, 1'b0, CW'(8));
    exp_frame = '0;
    for (int i = 0; i < 8; i++) exp_frame[BW*i +: BW] = BW'(i + 1);
    checkOutput("s1_frame", bus.send_msg, exp_frame);
    checkOutput("s1_len", W'(bus.send_len), W'(8));
    drain();

    // Scenario 2: back-to-back length-4 frames with downstream always ready
    $display("[TB] back-to-back length 4");
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b1, BW'(32'h10 + k), 1'b0, 1'b1, CW'(4));
      checkOutput("s2_recv_rdy", W'(bus.recv_rdy), W'(1));
      stepCycle();
    end
    drain();

    // Scenario 3: both buffers full, then a single send frees one
    $display("[TB] double buffer stall");
    feed(4, 32'h31, 1'b0, CW'(2));
    checkOutput("s3_rdy_low", W'(bus.recv_rdy), W'(0));
    applyStimulus(1'b0, '0, 1'b0, 1'b1, CW'(2));
    stepCycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, CW'(2));
    checkOutput("s3_val", W'(bus.send_val), W'(1));
    checkOutput("s3_lane0", W'(bus.send_msg[BW-1:0]), W'(32'h33));
    checkOutput("s3_rdy_back", W'(bus.recv_rdy), W'(1));
    stepCycle();
    drain();

    // Scenario 4: out-of-range lengths clamp; mid-frame cfg changes are ignored
    $display("[TB] length clamping");
    feed(8, 32'h40, 1'b0, CW'(0));
    checkOutput("s4_len0", W'(bus.send_len), W'(8));
    drain();
    feed(8, 32'h50, 1'b0, CW'(9));
    checkOutput("s4_len9", W'(bus.send_len), W'(8));
    drain();
    feed(1, 32'h60, 1'b0, CW'(3));
    feed(7, 32'h61, 1'b0, CW'(5));
    checkOutput("s4_first_len", W'(bus.send_len), W'(3));
    drain();

    // Scenario 5: early termination (flush build) or wait for full length
`ifdef DESERIALIZER_FLUSH_EN
    $display("[TB] flush");
    feed(2, 32'hAA, 1'b0, CW'(8));
    applyStimulus(1'b1, 32'hCC, 1'b1, 1'b0, CW'(8));
    stepCycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, CW'(8));
    exp_frame = '0;
    exp_frame[BW*0 +: BW] = 32'hAA;
    exp_frame[BW*1 +: BW] = 32'hAB;
    exp_frame[BW*2 +: BW] = 32'hCC;
    checkOutput("s5_len", W'(bus.send_len), W'(3));
    checkOutput("s5_frame", bus.send_msg, exp_frame);
    drain();
`else
    $display("[TB] no flush");
    feed(3, 32'hAA, 1'b0, CW'(8));
    stepCycle();
    checkOutput("s5_wait", W'(bus.send_val), W'(0));
    feed(5, 32'hAD, 1'b0, CW'(8));
    checkOutput("s5_len", W'(bus.send_len), W'(8));
    drain();
`endif

    // Scenario 6: random stalls, lengths and data
    $display("[TB] random run");
    acc0  = accepted;
    sent0 = sent_lanes;
    guard = 0;
    while (accepted - acc0 < 1000 && guard < 30000) begin
`ifdef DESERIALIZER_FLUSH_EN
      applyStimulus($urandom_range(9, 0) < 7, BW'($urandom), $urandom_range(7, 0) == 0,
                    $urandom_range(9, 0) < 6, CW'($urandom_range(15, 0)));
`else
      applyStimulus($urandom_range(9, 0) < 7, BW'($urandom), 1'b0,
                    $urandom_range(9, 0) < 6, CW'($urandom_range(15, 0)));
`endif
      stepCycle();
      guard++;
    end
    checkOutput("rand_budget", W'(accepted - acc0 >= 1000), W'(1));
    guard = 0;
    while (cur_cnt != 0 && guard < 200) begin
      applyStimulus(1'b1, BW'($urandom), 1'b0, $urandom_range(1, 0) == 1, CW'(8));
      stepCycle();
      guard++;
    end
    checkOutput("rand_complete", W'(cur_cnt), W'(0));
    drain();
    checkOutput("rand_no_loss", W'(sent_lanes - sent0), W'(accepted - acc0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
